instr_fetch_unit: RTL

// - Producer end of the decoder's instr interface: generates the PC stream and issues word fetches to instruction memory.
// - Buffers in-order responses in a small FIFO and presents {instr, instr_pc} to decode over a valid/ready handshake.
// - Handles redirects (branch/jump/trap) by flushing the FIFO and dropping stale in-flight responses.

---
 rtl/instr_fetch_unit_if.sv | 50 +++++
 rtl/instr_fetch_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Bundle of fetch-side handshakes: imem request/response, redirect, and the instr stream to decode.
// IFETCH_MISALIGN_EN adds the instr_misaligned flag alongside instr/instr_pc.
interface instr_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef IFETCH_MISALIGN_EN
  logic        instr_misaligned;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr, instr_pc, instr_misaligned,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr, instr_pc, instr_misaligned,
    output instr_ready
  );
`else
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );
`endif
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC generation, credit-limited imem requests, in-order response FIFO, redirect flush.
// Define IFETCH_MISALIGN_EN to report misaligned redirect targets instead of silently aligning them.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
`ifdef IFETCH_MISALIGN_EN
  localparam int unsigned EntryW = 65;
`else
  localparam int unsigned EntryW = 64;
`endif

  logic [31:0]       pc_q, pc_d;
  logic [CntW-1:0]   outstanding_q, outstanding_d;
  logic [CntW-1:0]   drop_q, drop_d;
  logic [CntW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0]   fifo_wr_q, fifo_wr_d;
  logic [PtrW-1:0]   fifo_rd_q, fifo_rd_d;
  logic [PtrW-1:0]   pcq_wr_q, pcq_wr_d;
  logic [PtrW-1:0]   pcq_rd_q, pcq_rd_d;
  logic [EntryW-1:0] fifo_mem [FIFO_DEPTH];
  logic [31:0]       pcq_mem  [FIFO_DEPTH];

  logic              fifo_we;
  logic [PtrW-1:0]   fifo_waddr;
  logic [EntryW-1:0] fifo_wdata;
  logic [EntryW-1:0] head;

  logic [CntW:0]     inflight;
  logic              credit_ok;
  logic              halted;
  logic              req_valid;
  logic              req_hs;
  logic              rsp;
  logic              fifo_empty;
  logic              instr_valid;
  logic              pop;
  logic              push;

`ifdef IFETCH_MISALIGN_EN
  logic halted_q, halted_d;
  always_comb halted = halted_q;
`else
  always_comb halted = 1'b0;
`endif

  // Credit counts stale in-flight requests too, so every response always finds a free slot.
  always_comb begin
    inflight    = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
    credit_ok   = inflight < (CntW + 1)'(FIFO_DEPTH);
    req_valid   = !rst && credit_ok && !halted;
    req_hs      = req_valid && bus.imem_req_ready;
    rsp         = bus.imem_rsp_valid;
    fifo_empty  = (fifo_cnt_q == '0);
    instr_valid = !rst && !fifo_empty && !bus.redirect_valid;
    pop         = instr_valid && bus.instr_ready;
    push        = rsp && (drop_q == '0) && !bus.redirect_valid;
    head        = fifo_mem[fifo_rd_q];
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.instr_valid    = instr_valid;
  assign bus.instr          = (!rst && !fifo_empty) ? head[EntryW-1 -: 32] : 32'h0;
  assign bus.instr_pc       = (!rst && !fifo_empty) ? head[EntryW-33 -: 32] : 32'h0;
`ifdef IFETCH_MISALIGN_EN
  assign bus.instr_misaligned = !rst && !fifo_empty && head[0];
`endif

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q + CntW'(req_hs) - CntW'(rsp);
    drop_d        = drop_q;
    fifo_cnt_d    = fifo_cnt_q;
    fifo_wr_d     = fifo_wr_q;
    fifo_rd_d     = fifo_rd_q;
    pcq_wr_d      = pcq_wr_q + PtrW'(req_hs);
    pcq_rd_d      = pcq_rd_q + PtrW'(rsp);
    fifo_we       = 1'b0;
    fifo_waddr    = fifo_wr_q;
`ifdef IFETCH_MISALIGN_EN
    halted_d      = halted_q;
    fifo_wdata    = {bus.imem_rsp_data, pcq_mem[pcq_rd_q], 1'b0};
`else
    fifo_wdata    = {bus.imem_rsp_data, pcq_mem[pcq_rd_q]};
`endif

    if (bus.redirect_valid) begin
      // Everything in flight after this cycle is stale, including a request accepted right now.
      pc_d       = bus.redirect_pc & 32'hFFFF_FFFC;
      drop_d     = outstanding_d;
      fifo_cnt_d = '0;
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
`ifdef IFETCH_MISALIGN_EN
      halted_d = (bus.redirect_pc[1:0] != 2'b00);
      if (bus.redirect_pc[1:0] != 2'b00) begin
        fifo_we    = 1'b1;
        fifo_waddr = '0;
        fifo_wdata = {32'h0, bus.redirect_pc, 1'b1};
        fifo_wr_d  = PtrW'(1);
        fifo_cnt_d = CntW'(1);
      end
`endif
    end else begin
      if (req_hs) begin
        pc_d = pc_q + 32'd4;
      end
      if (rsp && (drop_q != '0)) begin
        drop_d = drop_q - CntW'(1);
      end
      fifo_we    = push;
      fifo_wr_d  = fifo_wr_q + PtrW'(push);
      fifo_rd_d  = fifo_rd_q + PtrW'(pop);
      fifo_cnt_d = fifo_cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      fifo_cnt_q    <= '0;
      fifo_wr_q     <= '0;
      fifo_rd_q     <= '0;
      pcq_wr_q      <= '0;
      pcq_rd_q      <= '0;
`ifdef IFETCH_MISALIGN_EN
      halted_q      <= 1'b0;
`endif
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      fifo_cnt_q    <= fifo_cnt_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_rd_q     <= fifo_rd_d;
      pcq_wr_q      <= pcq_wr_d;
      pcq_rd_q      <= pcq_rd_d;
`ifdef IFETCH_MISALIGN_EN
      halted_q      <= halted_d;
`endif
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and counters above.
  always_ff @(posedge clk) begin
    if (fifo_we) begin
      fifo_mem[fifo_waddr] <= fifo_wdata;
    end
    if (req_hs) begin
      pcq_mem[pcq_wr_q] <= pc_q;
    end
  end

endmodule
